trap_arbiter: RTL and testbench

Parametrised trap-selection block between the commit stage and the CSR unit. It synchronises external interrupt lines and latches them as pending, masks them by enable and privilege, and delegates each trap to M or S mode. Each cycle it picks one trap, either the synchronous exception offered by commit or the highest-priority enabled interrupt. The chosen trap is presented to the CSR unit as a registered valid/ready transaction carrying cause, value and target privilege, encoded per the RISC-V exception-code, interrupt-code and privilege encodings.

---
 rtl/trap_arbiter.sv | 136 +++++++++++++
 tb/tb_trap_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_arbiter.sv
// Trap selection between commit and the CSR unit: synchronises and masks interrupts,
// delegates to M/S, and presents one trap at a time as a valid/ready transaction.
module trap_arbiter #(
  parameter int NUM_IRQ     = 12,
  parameter int CAUSE_WIDTH = 4,
  parameter int XLEN        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_IRQ-1:0]     irq,
  input  logic [NUM_IRQ-1:0]     mie,
  input  logic [NUM_IRQ-1:0]     mideleg,
  input  logic [15:0]            medeleg,
  input  logic [1:0]             priv,
  input  logic                   mstatus_mie,
  input  logic                   mstatus_sie,
  input  logic                   exc_valid,
  output logic                   exc_ready,
  input  logic [3:0]             exc_code,
  input  logic [XLEN-1:0]        exc_value,
  output logic                   trap_valid,
  input  logic                   trap_ready,
  output logic                   trap_is_irq,
  output logic [CAUSE_WIDTH-1:0] trap_cause,
  output logic [XLEN-1:0]        trap_value,
  output logic [1:0]             trap_priv,
  output logic [NUM_IRQ-1:0]     mip
);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLDOFF} state_t;

  // Standard interrupt codes packed lowest priority at [3:0], highest (11) at [35:32].
  localparam logic [35:0] STD_ORDER = {4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5, 4'd8, 4'd0, 4'd4};

  state_t                   state, state_n;
  logic [NUM_IRQ-1:0]       sync1;
  logic [NUM_IRQ-1:0]       elig;
  logic [NUM_IRQ-1:0]       irq_to_s;
  logic [11:0]              elig_std;
  logic                     m_en, s_en;
  logic                     irq_any;
  logic [CAUSE_WIDTH-1:0]   irq_cause;
  logic                     irq_sel_s;
  logic [3:0]               std_idx;
  logic                     exc_to_s;
  logic                     load_exc, load_irq;

  assign m_en     = (priv != 2'b11) | mstatus_mie;
  assign s_en     = (priv == 2'b00) | ((priv == 2'b01) & mstatus_sie);
  assign exc_to_s = medeleg[exc_code] & (priv != 2'b11);

  always_comb begin
    elig     = '0;
    irq_to_s = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      irq_to_s[i] = mideleg[i] & (priv != 2'b11);
      elig[i]     = mip[i] & mie[i] & (irq_to_s[i] ? s_en : m_en);
    end
  end

  assign elig_std = elig[11:0];

  // Platform lines first (lowest index wins), then standard lines override in rising priority.
  always_comb begin
    irq_any   = 1'b0;
    irq_cause = '0;
    irq_sel_s = 1'b0;
    std_idx   = '0;
    for (int unsigned i = 12; i < NUM_IRQ; i++) begin
      if (elig[i] && !irq_any) begin
        irq_any   = 1'b1;
        irq_cause = CAUSE_WIDTH'(i);
        irq_sel_s = irq_to_s[i];
      end
    end
    for (int unsigned k = 0; k < 9; k++) begin
      std_idx = STD_ORDER[k*4 +: 4];
      if (elig_std[std_idx]) begin
        irq_any   = 1'b1;
        irq_cause = CAUSE_WIDTH'(std_idx);
        irq_sel_s = irq_to_s[std_idx];
      end
    end
  end

  always_comb begin
    state_n  = state;
    load_exc = 1'b0;
    load_irq = 1'b0;
    case (state)
      IDLE: begin
        if (exc_valid) begin
          load_exc = 1'b1;
          state_n  = PRESENT;
        end else if (irq_any) begin
          load_irq = 1'b1;
          state_n  = PRESENT;
        end
      end
      PRESENT: if (trap_ready) state_n = HOLDOFF;
      HOLDOFF: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign exc_ready  = (state == IDLE);
  assign trap_valid = (state == PRESENT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sync1       <= '0;
      mip         <= '0;
      trap_is_irq <= 1'b0;
      trap_cause  <= '0;
      trap_value  <= '0;
      trap_priv   <= 2'b11;
    end else begin
      state <= state_n;
      sync1 <= irq;
      mip   <= sync1;
      if (load_exc) begin
        trap_is_irq <= 1'b0;
        trap_cause  <= CAUSE_WIDTH'(exc_code);
        trap_value  <= exc_value;
        trap_priv   <= exc_to_s ? 2'b01 : 2'b11;
      end else if (load_irq) begin
        trap_is_irq <= 1'b1;
        trap_cause  <= irq_cause;
        trap_value  <= '0;
        trap_priv   <= irq_sel_s ? 2'b01 : 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_trap_arbiter.sv
// Self-checking bench for trap_arbiter (NUM_IRQ=16): directed scenarios plus
// randomized trials checked against a priority-list reference model.
module tb_trap_arbiter;
  localparam int N  = 16;
  localparam int CW = 4;
  localparam int XL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq, mie, mideleg, mip;
  logic [15:0]   medeleg;
  logic [1:0]    priv;
  logic          mstatus_mie, mstatus_sie;
  logic          exc_valid, exc_ready;
  logic [3:0]    exc_code;
  logic [XL-1:0] exc_value;
  logic          trap_valid, trap_ready, trap_is_irq;
  logic [CW-1:0] trap_cause;
  logic [XL-1:0] trap_value;
  logic [1:0]    trap_priv;

  int checks = 0;
  int failures = 0;

  trap_arbiter #(.NUM_IRQ(N), .CAUSE_WIDTH(CW), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mie(mie), .mideleg(mideleg), .medeleg(medeleg),
    .priv(priv), .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
    .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_code(exc_code), .exc_value(exc_value),
    .trap_valid(trap_valid), .trap_ready(trap_ready), .trap_is_irq(trap_is_irq),
    .trap_cause(trap_cause), .trap_value(trap_value), .trap_priv(trap_priv), .mip(mip)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns the 0-based tick index on which trap_valid was seen, or -1 on timeout.
  task automatic wait_valid(input int max_ticks, output int seen);
    seen = -1;
    for (int k = 0; k < max_ticks && seen < 0; k++) begin
      tick();
      if (trap_valid === 1'b1) seen = k;
    end
  endtask

  task automatic drain;
    irq = '0;
    exc_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      trap_ready = 1'b1;
      tick();
    end
    trap_ready = 1'b0;
    repeat (3) tick();
  endtask

  // Reference: walk the architectural priority list, first eligible line wins.
  function automatic void model_irq(output bit any, output int cause, output logic [1:0] tp);
    int  prio [13];
    int  i;
    bit  to_s, en;
    prio = '{11, 3, 7, 9, 1, 5, 8, 0, 4, 12, 13, 14, 15};
    any = 1'b0; cause = 0; tp = 2'b11;
    for (int j = 0; j < 13; j++) begin
      i = prio[j];
      to_s = mideleg[i] && (priv != 2'b11);
      en = to_s ? (priv == 2'b00 || (priv == 2'b01 && mstatus_sie))
                : (priv != 2'b11 || mstatus_mie);
      if (!any && irq[i] && mie[i] && en) begin
        any = 1'b1; cause = i; tp = to_s ? 2'b01 : 2'b11;
      end
    end
  endfunction

  task automatic test_reset;
    checks++;
    if (trap_valid !== 1'b0 || exc_ready !== 1'b1 || trap_is_irq !== 1'b0 ||
        trap_cause !== '0 || trap_value !== '0 || trap_priv !== 2'b11 || mip !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b ready=%b irq=%b cause=%h value=%h priv=%b mip=%h, want 0 1 0 0 0 11 0",
               trap_valid, exc_ready, trap_is_irq, trap_cause, trap_value, trap_priv, mip);
    end
  endtask

  task automatic test_irq_latency;
    mie = '0; mie[7] = 1'b1; mideleg = '0; priv = 2'b00;
    irq = '0; irq[7] = 1'b1;
    tick();
    checks++;
    if (trap_valid !== 1'b0 || mip[7] !== 1'b0) begin
      failures++; $display("FAIL latency_t1: valid=%b mip7=%b want 0 0", trap_valid, mip[7]);
    end
    tick();
    checks++;
    if (trap_valid !== 1'b0 || mip[7] !== 1'b1) begin
      failures++; $display("FAIL latency_t2: valid=%b mip7=%b want 0 1", trap_valid, mip[7]);
    end
    tick();
    checks++;
    if (trap_valid !== 1'b1 || trap_is_irq !== 1'b1 || trap_cause !== 4'd7 ||
        trap_priv !== 2'b11 || trap_value !== '0) begin
      failures++;
      $display("FAIL latency_t3: valid=%b irq=%b cause=%0d priv=%b value=%h want 1 1 7 11 0",
               trap_valid, trap_is_irq, trap_cause, trap_priv, trap_value);
    end
    drain();
  endtask

  task automatic test_priority;
    int seen;
    mie = '1; mideleg = '0; priv = 2'b11; mstatus_mie = 1'b1;
    irq = '0; irq[7] = 1'b1; irq[11] = 1'b1;
    wait_valid(6, seen);
    checks++;
    if (seen < 0 || trap_cause !== 4'd11 || trap_priv !== 2'b11) begin
      failures++; $display("FAIL prio_first: seen=%0d cause=%0d priv=%b want cause 11 priv 11", seen, trap_cause, trap_priv);
    end
    irq[11] = 1'b0;
    trap_ready = 1'b1;
    tick();
    trap_ready = 1'b0;
    checks++;
    if (trap_valid !== 1'b0 || exc_ready !== 1'b0) begin
      failures++; $display("FAIL prio_holdoff: valid=%b ready=%b want 0 0", trap_valid, exc_ready);
    end
    wait_valid(6, seen);
    checks++;
    if (seen < 0 || trap_cause !== 4'd7 || trap_is_irq !== 1'b1) begin
      failures++; $display("FAIL prio_second: seen=%0d cause=%0d want 7", seen, trap_cause);
    end
    drain();
    mstatus_mie = 1'b0;
  endtask

  task automatic test_exc_beats_irq;
    mie = '0; mie[3] = 1'b1; mideleg = '0; priv = 2'b00; medeleg = '0; medeleg[13] = 1'b1;
    irq = '0; irq[3] = 1'b1;
    tick();
    tick();
    exc_valid = 1'b1; exc_code = 4'hd; exc_value = 32'h8000_1000;
    tick();
    exc_valid = 1'b0;
    checks++;
    if (trap_valid !== 1'b1 || trap_is_irq !== 1'b0 || trap_cause !== 4'hd ||
        trap_value !== 32'h8000_1000 || trap_priv !== 2'b01) begin
      failures++;
      $display("FAIL exc_wins: valid=%b irq=%b cause=%h value=%h priv=%b want 1 0 d 80001000 01",
               trap_valid, trap_is_irq, trap_cause, trap_value, trap_priv);
    end
    drain();
    medeleg = '0;
  endtask

  task automatic test_global_enable;
    bit leaked;
    mie = '1; mideleg = '0; priv = 2'b11; mstatus_mie = 1'b0;
    irq = '0; irq[11] = 1'b1;
    leaked = 1'b0;
    repeat (20) begin
      tick();
      if (trap_valid !== 1'b0) leaked = 1'b1;
    end
    checks++;
    if (leaked) begin
      failures++; $display("FAIL gmie_masked: trap_valid rose with mstatus_mie=0, want no trap");
    end
    mstatus_mie = 1'b1;
    tick();
    checks++;
    if (trap_valid !== 1'b1 || trap_cause !== 4'd11) begin
      failures++; $display("FAIL gmie_enable: valid=%b cause=%0d want 1 11", trap_valid, trap_cause);
    end
    drain();
    mstatus_mie = 1'b0;
  endtask

  task automatic test_stall;
    int  seen;
    bit  moved;
    mie = '1; mideleg = '0; priv = 2'b00;
    irq = '0; irq[9] = 1'b1;
    wait_valid(6, seen);
    checks++;
    if (seen < 0 || trap_cause !== 4'd9) begin
      failures++; $display("FAIL stall_start: seen=%0d cause=%0d want 9", seen, trap_cause);
    end
    exc_valid = 1'b1; exc_code = 4'h2; exc_value = 32'hdead_beef;
    moved = 1'b0;
    repeat (10) begin
      irq = N'($urandom);
      tick();
      if (trap_valid !== 1'b1 || exc_ready !== 1'b0 || trap_is_irq !== 1'b1 ||
          trap_cause !== 4'd9 || trap_value !== '0 || trap_priv !== 2'b11) moved = 1'b1;
    end
    checks++;
    if (moved) begin
      failures++; $display("FAIL stall_hold: outputs changed while trap_ready low (cause=%0d irq=%b)", trap_cause, trap_is_irq);
    end
    irq = '0; exc_valid = 1'b0; trap_ready = 1'b1;
    tick();
    trap_ready = 1'b0;
    checks++;
    if (trap_valid !== 1'b0 || exc_ready !== 1'b0) begin
      failures++; $display("FAIL stall_release: valid=%b ready=%b want 0 0", trap_valid, exc_ready);
    end
    tick();
    checks++;
    if (exc_ready !== 1'b1 || trap_valid !== 1'b0) begin
      failures++; $display("FAIL stall_idle: ready=%b valid=%b want 1 0", exc_ready, trap_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    int seen;
    priv = 2'b00; medeleg = '0;
    exc_valid = 1'b1; exc_code = 4'h5; exc_value = 32'h1234_5678;
    tick();
    exc_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    test_reset();
    #2 rst = 1'b0;
    tick();
    mie = '1; mideleg = '0; priv = 2'b00;
    irq = '0; irq[14] = 1'b1;
    wait_valid(6, seen);
    checks++;
    if (seen != 2 || trap_cause !== 4'd14 || trap_is_irq !== 1'b1 || trap_priv !== 2'b11) begin
      failures++; $display("FAIL reset_then_irq14: seen=%0d cause=%0d priv=%b want tick 2 cause 14 priv 11", seen, trap_cause, trap_priv);
    end
    drain();
  endtask

  task automatic test_random;
    bit          do_exc, any;
    int          cause, seen, want_tick;
    logic [1:0]  tp;
    logic [1:0]  privs [3];
    privs = '{2'b00, 2'b01, 2'b11};
    for (int t = 0; t < 40; t++) begin
      mie = N'($urandom); mideleg = N'($urandom); medeleg = 16'($urandom);
      priv = privs[$urandom_range(0, 2)];
      mstatus_mie = 1'($urandom); mstatus_sie = 1'($urandom);
      irq = N'($urandom) & N'($urandom);
      do_exc = ($urandom_range(0, 3) == 0);
      exc_code = 4'($urandom); exc_value = $urandom;
      exc_valid = do_exc;
      if (do_exc) begin
        any = 1'b1; cause = int'(exc_code); want_tick = 0;
        tp = (medeleg[exc_code] && priv != 2'b11) ? 2'b01 : 2'b11;
      end else begin
        model_irq(any, cause, tp); want_tick = 2;
      end
      wait_valid(6, seen);
      exc_valid = 1'b0;
      checks++;
      if ((seen >= 0) != any || (any && seen != want_tick)) begin
        failures++; $display("FAIL rand_present[%0d]: seen tick %0d, want %0d (trap expected=%0d)", t, seen, want_tick, any);
      end else if (any) begin
        checks++;
        if (trap_is_irq !== !do_exc || trap_cause !== CW'(cause) || trap_priv !== tp ||
            trap_value !== (do_exc ? exc_value : '0)) begin
          failures++;
          $display("FAIL rand_fields[%0d]: irq=%b cause=%0d priv=%b value=%h want %b %0d %b %h",
                   t, trap_is_irq, trap_cause, trap_priv, trap_value, !do_exc, cause, tp, do_exc ? exc_value : '0);
        end
      end
      drain();
    end
  endtask

  initial begin
    rst = 1'b1; irq = '0; mie = '0; mideleg = '0; medeleg = '0; priv = 2'b11;
    mstatus_mie = 1'b0; mstatus_sie = 1'b0; exc_valid = 1'b0; exc_code = '0;
    exc_value = '0; trap_ready = 1'b0;
    repeat (2) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_irq_latency();
    test_priority();
    test_exc_beats_irq();
    test_global_enable();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
